// File: rtl/clk_gate_ctrl_pkg.sv
// Shared state encoding and width helpers for the clock-gating controller.
package clk_gate_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_OFF  = 2'b00,
        ST_WAKE = 2'b01,
        ST_ON   = 2'b10,
        ST_BAD  = 2'b11
    } dom_state_e;

    // Bits needed to hold 0..max_val, never fewer than one.
    function automatic int cnt_width(input int max_val);
        return (max_val < 2) ? 1 : $clog2(max_val + 1);
    endfunction

    function automatic int on_cnt_width(input int n);
        return $clog2(n + 1);
    endfunction

    function automatic int ptr_width(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/clk_gate_ctrl_dom_fsm.sv
// Per-domain OFF/WAKE/ON sequencer driving one gate cell's enable and ACK.
module clk_gate_dom_fsm
    import clk_gate_ctrl_pkg::*;
#(
    parameter int IDLE_CYC = 16,
    parameter int WAKE_CYC = 2
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       grant_i,
    input  logic       req_i,
    input  logic       busy_i,
    input  logic       freeze_i,
    output logic       e_o,
    output logic       ack_o,
    output logic       active_o,
    output dom_state_e state_o
);

    localparam int IW = cnt_width(IDLE_CYC);
    localparam int WW = cnt_width(WAKE_CYC);
    localparam logic [IW-1:0] IDLE_LAST = IW'(IDLE_CYC - 1);
    localparam logic [WW-1:0] WAKE_LAST = WW'(WAKE_CYC - 1);

    dom_state_e    state_q, state_d;
    logic [WW-1:0] wake_cnt_q, wake_cnt_d;
    logic [IW-1:0] idle_cnt_q, idle_cnt_d;
    logic          first_on_q, first_on_d;
    logic          quiet;

    // The first ON cycle counts as active, so idling starts once ACK is visible.
    assign quiet = ~(req_i | busy_i) & ~first_on_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= ST_OFF;
            wake_cnt_q <= '0;
            idle_cnt_q <= '0;
            first_on_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            wake_cnt_q <= wake_cnt_d;
            idle_cnt_q <= idle_cnt_d;
            first_on_q <= first_on_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        wake_cnt_d = wake_cnt_q;
        idle_cnt_d = idle_cnt_q;
        first_on_d = first_on_q;
        if (!freeze_i) begin
            case (state_q)
                ST_OFF: begin
                    if (grant_i) begin
                        state_d    = ST_WAKE;
                        wake_cnt_d = '0;
                    end
                end
                ST_WAKE: begin
                    if (wake_cnt_q == WAKE_LAST) begin
                        state_d    = ST_ON;
                        wake_cnt_d = '0;
                        idle_cnt_d = '0;
                        first_on_d = 1'b1;
                    end else begin
                        wake_cnt_d = wake_cnt_q + 1'b1;
                    end
                end
                ST_ON: begin
                    first_on_d = 1'b0;
                    if (!quiet) begin
                        idle_cnt_d = '0;
                    end else if (idle_cnt_q == IDLE_LAST) begin
                        // This idle cycle brings the count to IDLE_CYC.
                        state_d    = ST_OFF;
                        idle_cnt_d = '0;
                    end else begin
                        idle_cnt_d = idle_cnt_q + 1'b1;
                    end
                end
                default: begin
                    state_d    = ST_OFF;
                    wake_cnt_d = '0;
                    idle_cnt_d = '0;
                    first_on_d = 1'b0;
                end
            endcase
        end
    end

    always_comb begin
        e_o   = 1'b0;
        ack_o = 1'b0;
        case (state_q)
            ST_WAKE: e_o = 1'b1;
            ST_ON: begin
                e_o   = 1'b1;
                ack_o = 1'b1;
            end
            default: begin
                e_o   = 1'b0;
                ack_o = 1'b0;
            end
        endcase
    end

    assign active_o = e_o;
    assign state_o  = state_q;

endmodule

// File: rtl/clk_gate_ctrl.sv
// Clock-gate bank controller: round-robin admission under an ON budget, test freeze.
module clk_gate_ctrl
    import clk_gate_ctrl_pkg::*;
#(
    parameter int N        = 4,
    parameter int IDLE_CYC = 16,
    parameter int WAKE_CYC = 2,
    parameter int MAX_ON   = 2,
    localparam int CW      = on_cnt_width(N),
    localparam int PW      = ptr_width(N)
) (
    input  logic            ck_i,
    input  logic            rst_i,
    input  logic            te_i,
    input  logic [N-1:0]    req_i,
    input  logic [N-1:0]    busy_i,
    output logic [N-1:0]    e_o,
    output logic            se_o,
    output logic [N-1:0]    ack_o,
    output logic [CW-1:0]   on_cnt_o,
    output logic [PW-1:0]   dbg_ptr_o,
    output logic [2*N-1:0]  dbg_state_o
);

    logic [N-1:0]  active;
    logic [N-1:0]  cand;
    logic [N-1:0]  grant;
    logic [CW-1:0] on_cnt;
    logic [PW-1:0] ptr_q, ptr_d;
    logic [PW-1:0] scan_idx;
    logic [PW-1:0] grant_idx;
    logic          grant_vld;
    logic          se_q;

    always_ff @(posedge ck_i) begin
        if (rst_i) begin
            ptr_q <= '0;
            se_q  <= 1'b0;
        end else begin
            ptr_q <= ptr_d;
            se_q  <= te_i;
        end
    end

    always_comb begin
        on_cnt = '0;
        for (int i = 0; i < N; i++) begin
            on_cnt = on_cnt + CW'(active[i]);
        end
    end

    assign cand = req_i & ~active;

    // First requesting OFF domain at or after the pointer; budget uses the pre-edge count.
    always_comb begin
        grant_vld = 1'b0;
        grant_idx = '0;
        scan_idx  = '0;
        for (int k = 0; k < N; k++) begin
            scan_idx = PW'((int'(ptr_q) + k) % N);
            if (!grant_vld && cand[scan_idx]) begin
                grant_vld = 1'b1;
                grant_idx = scan_idx;
            end
        end
        if (te_i || (on_cnt >= CW'(MAX_ON))) begin
            grant_vld = 1'b0;
        end
    end

    always_comb begin
        grant = '0;
        if (grant_vld) begin
            grant[grant_idx] = 1'b1;
        end
    end

    always_comb begin
        ptr_d = ptr_q;
        if (grant_vld) begin
            ptr_d = (grant_idx == PW'(N - 1)) ? '0 : grant_idx + 1'b1;
        end
    end

    for (genvar i = 0; i < N; i++) begin : g_dom
        dom_state_e st;

        clk_gate_dom_fsm #(
            .IDLE_CYC (IDLE_CYC),
            .WAKE_CYC (WAKE_CYC)
        ) u_fsm (
            .clk_i    (ck_i),
            .rst_i    (rst_i),
            .grant_i  (grant[i]),
            .req_i    (req_i[i]),
            .busy_i   (busy_i[i]),
            .freeze_i (te_i),
            .e_o      (e_o[i]),
            .ack_o    (ack_o[i]),
            .active_o (active[i]),
            .state_o  (st)
        );

        assign dbg_state_o[2*i +: 2] = st;
    end

    assign se_o      = se_q;
    assign on_cnt_o  = on_cnt;
    assign dbg_ptr_o = ptr_q;

endmodule
